// File: rtl/cbus_ram_responder.sv
// CBus memory responder: latches a request, waits LATENCY cycles, then streams
// one 64-bit beat per cycle from an internal word-addressed RAM with byte-strobed writes.
package cbus_pkg;
   localparam logic [1:0] CBUS_FIXED = 2'd0;
   localparam logic [1:0] CBUS_INCR  = 2'd1;
   localparam logic [1:0] CBUS_WRAP  = 2'd2;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [3:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module cbus_ram_responder
   import cbus_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp,
   output logic       busy
);
   localparam int unsigned   AW       = $clog2(MEM_WORDS);
   localparam logic [3:0]    LAT4     = 4'(LATENCY);
   localparam bit            HAS_WAIT = (LATENCY != 32'd0);
   localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2} state_t;

   state_t        state_r, state_s;
   logic [3:0]    wcnt_r, wcnt_s;
   logic [3:0]    cnt_r, cnt_s;
   logic [3:0]    len_r, len_s;
   logic [1:0]    burst_r, burst_s;
   logic          is_write_r, is_write_s;
   logic [AW-1:0] idx_r, idx_s;
   logic [63:0]   offset_s;
   logic          we_s;
   logic          unused_s;

   logic [63:0]   mem [MEM_WORDS];

   // WRAP keeps the upper index bits and rolls the low log2(len+1) bits
   function automatic logic [AW-1:0] advance_idx(input logic [AW-1:0] idx,
                                                 input logic [1:0]    burst,
                                                 input logic [3:0]    len);
      logic [AW-1:0] mask;
      mask = AW'(len);
      case (burst)
         CBUS_FIXED: advance_idx = idx;
         CBUS_WRAP:  advance_idx = (idx & ~mask) | ((idx + IDX_ONE) & mask);
         default:    advance_idx = idx + IDX_ONE;
      endcase
   endfunction

   assign offset_s = creq.addr - BASE_ADDR;
   assign unused_s = ^{creq.size, offset_s[63:AW+3], offset_s[2:0]};
   assign we_s     = (state_r == BURST) && creq.valid && is_write_r;
   assign busy     = (state_r != IDLE);

   // Next-state and burst bookkeeping
   always_comb begin
      state_s    = state_r;
      wcnt_s     = wcnt_r;
      cnt_s      = cnt_r;
      len_s      = len_r;
      burst_s    = burst_r;
      is_write_s = is_write_r;
      idx_s      = idx_r;
      case (state_r)
         IDLE: begin
            if (creq.valid) begin
               is_write_s = creq.is_write;
               len_s      = creq.len;
               burst_s    = creq.burst;
               idx_s      = offset_s[AW+2:3];
               cnt_s      = 4'd0;
               if (HAS_WAIT) begin
                  state_s = WAIT;
                  wcnt_s  = LAT4;
               end else begin
                  state_s = BURST;
                  wcnt_s  = 4'd0;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            wcnt_s = wcnt_r - 4'd1;
            if (!creq.valid) begin
               state_s = IDLE;
               wcnt_s  = 4'd0;
            end else if (wcnt_r <= 4'd1) begin
               state_s = BURST;
            end else begin
               state_s = WAIT;
            end
         end
         BURST: begin
            if (!creq.valid || (cnt_r == len_r)) begin
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r + 4'd1;
               idx_s = advance_idx(idx_r, burst_r, len_r);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         wcnt_r     <= 4'd0;
         cnt_r      <= 4'd0;
         len_r      <= 4'd0;
         burst_r    <= 2'd0;
         is_write_r <= 1'b0;
         idx_r      <= '0;
      end else begin
         state_r    <= state_s;
         wcnt_r     <= wcnt_s;
         cnt_r      <= cnt_s;
         len_r      <= len_s;
         burst_r    <= burst_s;
         is_write_r <= is_write_s;
         idx_r      <= idx_s;
      end
   end

   // Byte-lane write port; storage survives reset
   always_ff @(posedge clk) begin
      if (we_s) begin
         for (int b = 0; b < 8; b++) begin
            if (creq.strobe[b]) begin
               mem[idx_r][b*8 +: 8] <= creq.data[b*8 +: 8];
            end
         end
      end
   end

   // Response: zero-latency read, handshake gated by the initiator's valid
   always_comb begin
      cresp = '0;
      if (state_r == BURST) begin
         cresp.ready = creq.valid;
         cresp.last  = creq.valid & (cnt_r == len_r);
         cresp.data  = mem[idx_r];
      end else begin
         cresp = '0;
      end
   end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// Self-checking bench for cbus_ram_responder: two instances (LATENCY 2 and 0)
// compared cycle by cycle against a word-array reference model.
module tb_cbus_ram_responder;
   import cbus_pkg::*;

   localparam logic [63:0] BASE = 64'h8000_0000;

   logic       clk;
   logic       reset;
   cbus_req_t  creq2, creq0;
   cbus_resp_t cresp2, cresp0;
   logic       busy2, busy0;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [63:0] model [2][1024];
   bit          known [2][1024];
   logic [63:0] wdata_q [16];
   logic [7:0]  strb_q [16];

   cbus_ram_responder #(.MEM_WORDS(1024), .LATENCY(2), .BASE_ADDR(BASE)) u_lat2 (
      .clk(clk), .reset(reset), .creq(creq2), .cresp(cresp2), .busy(busy2));
   cbus_ram_responder #(.MEM_WORDS(64), .LATENCY(0), .BASE_ADDR(BASE)) u_lat0 (
      .clk(clk), .reset(reset), .creq(creq0), .cresp(cresp0), .busy(busy0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input cbus_req_t r);
      if (d == 0) creq2 = r;
      else        creq0 = r;
   endtask

   function automatic cbus_resp_t resp(input int d);
      if (d == 0) return cresp2;
      else        return cresp0;
   endfunction

   function automatic logic get_busy(input int d);
      if (d == 0) return busy2;
      else        return busy0;
   endfunction

   // word touched by beat k of an n-beat burst starting at word start
   function automatic int beat_idx(input int start, input int n, input logic [1:0] bt,
                                   input int k, input int words);
      int base;
      case (bt)
         2'd0: return start;
         2'd2: begin
            base = start - (start % n);
            return base + ((start % n) + k) % n;
         end
         default: return (start + k) % words;
      endcase
   endfunction

   task automatic fill_seq(input logic [63:0] first);
      for (int i = 0; i < 16; i++) begin
         wdata_q[i] = first + 64'(i);
         strb_q[i]  = 8'hFF;
      end
   endtask

   task automatic fill_const(input logic [63:0] v, input logic [7:0] s);
      for (int i = 0; i < 16; i++) begin
         wdata_q[i] = v;
         strb_q[i]  = s;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 16; i++) begin
         wdata_q[i] = {$urandom, $urandom};
         strb_q[i]  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      end
   endtask

   // stop_kind: 0 none, 1 drop valid before beat stop_at, 2 async reset during beat stop_at
   task automatic do_burst(input int d, input bit wr, input logic [63:0] addr, input int n,
                           input logic [1:0] bt, input int stop_kind, input int stop_at,
                           input string tag);
      int lat, words, start, e;
      cbus_req_t  r;
      cbus_resp_t rs;
      lat   = (d == 0) ? 2 : 0;
      words = (d == 0) ? 1024 : 64;
      start = int'(((addr - BASE) >> 3) % 64'(words));
      r          = '0;
      r.valid    = 1'b1;
      r.is_write = wr;
      r.size     = 3'($urandom_range(0, 7));
      r.addr     = addr;
      r.len      = 4'(n - 1);
      r.burst    = bt;
      r.data     = wdata_q[0];
      r.strobe   = strb_q[0];
      @(negedge clk);
      drive(d, r);
      for (int c = 0; c < lat; c++) begin
         @(negedge clk); #1;
         rs = resp(d);
         check($sformatf("%s wait%0d ready", tag, c), 64'(rs.ready), 64'd0);
         check($sformatf("%s wait%0d busy", tag, c), 64'(get_busy(d)), 64'd1);
      end
      for (int k = 0; k < n; k++) begin
         e = beat_idx(start, n, bt, k, words);
         @(negedge clk);
         if (stop_kind == 1 && k == stop_at) begin
            r.valid = 1'b0;
            drive(d, r);
            #1;
            rs = resp(d);
            check($sformatf("%s abort ready", tag), 64'(rs.ready), 64'd0);
            check($sformatf("%s abort last", tag), 64'(rs.last), 64'd0);
            check($sformatf("%s abort busy", tag), 64'(get_busy(d)), 64'd1);
            @(negedge clk); #1;
            rs = resp(d);
            check($sformatf("%s abort busy_after", tag), 64'(get_busy(d)), 64'd0);
            check($sformatf("%s abort ready_after", tag), 64'(rs.ready), 64'd0);
            return;
         end
         r.data   = wdata_q[k];
         r.strobe = strb_q[k];
         drive(d, r);
         #1;
         rs = resp(d);
         check($sformatf("%s b%0d ready", tag, k), 64'(rs.ready), 64'd1);
         check($sformatf("%s b%0d last", tag, k), 64'(rs.last), 64'(k == n - 1));
         check($sformatf("%s b%0d busy", tag, k), 64'(get_busy(d)), 64'd1);
         if (known[d][e]) begin
            check($sformatf("%s b%0d data w%0d", tag, k, e), rs.data, model[d][e]);
         end
         if (stop_kind == 2 && k == stop_at) begin
            #2 reset = 1'b1;
            #1;
            rs = resp(d);
            check($sformatf("%s reset ready", tag), 64'(rs.ready), 64'd0);
            check($sformatf("%s reset last", tag), 64'(rs.last), 64'd0);
            check($sformatf("%s reset data", tag), rs.data, 64'd0);
            check($sformatf("%s reset busy", tag), 64'(get_busy(d)), 64'd0);
            @(negedge clk);
            r = '0;
            drive(d, r);
            reset = 1'b0;
            return;
         end
         if (wr) begin
            if (known[d][e]) begin
               for (int b = 0; b < 8; b++) begin
                  if (strb_q[k][b]) model[d][e][b*8 +: 8] = wdata_q[k][b*8 +: 8];
               end
            end else if (strb_q[k] == 8'hFF) begin
               model[d][e] = wdata_q[k];
               known[d][e] = 1'b1;
            end
         end
      end
      @(negedge clk);
      r.valid = 1'b0;
      drive(d, r);
      #1;
      rs = resp(d);
      check($sformatf("%s end ready", tag), 64'(rs.ready), 64'd0);
      check($sformatf("%s end busy", tag), 64'(get_busy(d)), 64'd0);
   endtask

   task automatic rand_burst(input int d, input int id);
      int          words, word, n;
      logic [63:0] addr;
      logic [1:0]  bt;
      bit          wr;
      words = (d == 0) ? 1024 : 64;
      word  = $urandom_range(0, (d == 0) ? 127 : 63);
      n     = 1 << $urandom_range(0, 4);
      bt    = 2'($urandom_range(0, 3));
      wr    = 1'($urandom_range(0, 1));
      addr  = BASE + 64'(word + words * int'($urandom_range(0, 3))) * 64'd8
              + 64'($urandom_range(0, 7));
      fill_rand();
      do_burst(d, wr, addr, n, bt, 0, 0, $sformatf("rnd%0d_%0d", d, id));
   endtask

   // two single-beat reads with valid held high across the gap (LATENCY 0)
   task automatic back_to_back();
      cbus_req_t r;
      r       = '0;
      r.valid = 1'b1;
      r.addr  = BASE + 64'd8;
      r.len   = 4'd0;
      r.burst = CBUS_INCR;
      @(negedge clk);
      creq0 = r;
      @(negedge clk); #1;
      check("b2b first ready", 64'(cresp0.ready), 64'd1);
      check("b2b first last", 64'(cresp0.last), 64'd1);
      check("b2b first data", cresp0.data, model[1][1]);
      r.addr = BASE + 64'd16;
      creq0  = r;
      @(negedge clk); #1;
      check("b2b gap ready", 64'(cresp0.ready), 64'd0);
      check("b2b gap busy", 64'(busy0), 64'd0);
      @(negedge clk); #1;
      check("b2b second ready", 64'(cresp0.ready), 64'd1);
      check("b2b second last", 64'(cresp0.last), 64'd1);
      check("b2b second data", cresp0.data, model[1][2]);
      r.valid = 1'b0;
      creq0   = r;
      @(negedge clk); #1;
      check("b2b end busy", 64'(busy0), 64'd0);
      check("b2b end ready", 64'(cresp0.ready), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      creq2 = '0;
      creq0 = '0;
      @(negedge clk); #1;
      check("rst ready2", 64'(cresp2.ready), 64'd0);
      check("rst last2", 64'(cresp2.last), 64'd0);
      check("rst data2", cresp2.data, 64'd0);
      check("rst busy2", 64'(busy2), 64'd0);
      check("rst ready0", 64'(cresp0.ready), 64'd0);
      check("rst data0", cresp0.data, 64'd0);
      check("rst busy0", 64'(busy0), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      fill_seq(64'd0);
      do_burst(0, 1'b1, BASE, 16, CBUS_INCR, 0, 0, "incr_wr");
      do_burst(0, 1'b0, BASE, 16, CBUS_INCR, 0, 0, "incr_rd");

      fill_const(64'hDEAD_BEEF_0123_4567, 8'hFF);
      do_burst(0, 1'b1, BASE + 64'h20, 1, CBUS_INCR, 0, 0, "pre4");
      do_burst(0, 1'b0, BASE + 64'h20, 1, CBUS_INCR, 0, 0, "single_rd");

      fill_const(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      do_burst(0, 1'b1, BASE, 1, CBUS_INCR, 0, 0, "strb_pre");
      fill_const(64'd0, 8'h0F);
      do_burst(0, 1'b1, BASE, 1, CBUS_INCR, 0, 0, "strb_wr");
      do_burst(0, 1'b0, BASE, 1, CBUS_INCR, 0, 0, "strb_rd");

      fill_seq(64'd4);
      do_burst(0, 1'b1, BASE + 64'h20, 4, CBUS_INCR, 0, 0, "wrap_pre");
      do_burst(0, 1'b0, BASE + 64'h30, 4, CBUS_WRAP, 0, 0, "wrap_rd");

      fill_rand();
      fill_const(64'h0123_4567_89AB_CDEF, 8'hFF);
      do_burst(0, 1'b1, BASE, 8, CBUS_INCR, 0, 0, "abort_pre");
      fill_rand();
      do_burst(0, 1'b1, BASE, 8, CBUS_INCR, 1, 3, "abort_wr");
      do_burst(0, 1'b0, BASE, 8, CBUS_INCR, 0, 0, "abort_rd");

      for (int i = 0; i < 12; i++) rand_burst(0, i);

      fill_seq(64'h100);
      do_burst(1, 1'b1, BASE + 64'd512 * 64'd5, 16, CBUS_INCR, 0, 0, "alias_wr");
      do_burst(1, 1'b0, BASE, 16, CBUS_INCR, 0, 0, "alias_rd");

      fill_rand();
      do_burst(1, 1'b1, BASE + 64'd160, 4, CBUS_FIXED, 0, 0, "fixed_wr");
      do_burst(1, 1'b0, BASE + 64'd160, 2, CBUS_FIXED, 0, 0, "fixed_rd");

      back_to_back();

      fill_const(64'h5A5A_A5A5_5A5A_A5A5, 8'hFF);
      do_burst(1, 1'b1, BASE + 64'd256, 16, CBUS_INCR, 0, 0, "rstmid_pre");
      fill_rand();
      do_burst(1, 1'b1, BASE + 64'd256, 16, CBUS_INCR, 2, 5, "rstmid_wr");
      do_burst(1, 1'b0, BASE + 64'd256, 16, CBUS_INCR, 0, 0, "rstmid_rd");

      for (int i = 0; i < 12; i++) rand_burst(1, i);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
